// File: rtl/multi_alarm_clock.sv
// 24-hour BCD real-time clock with several loadable alarm slots, snooze,
// ring timeout and a snooze limit. Runs directly on the 1 Hz tick clock.
module multi_alarm_clock #(
    parameter int unsigned NUM_ALARMS     = 4,
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned MAX_SNOOZE     = 3,
    localparam int unsigned AW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk_1s,
    input  logic                  reset,
    input  logic                  ld_time,
    input  logic                  ld_alarm,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic [NUM_ALARMS-1:0] al_en,
    input  logic                  snooze,
    input  logic                  stop_al,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0,
    output logic                  alarm,
    output logic [AW-1:0]         alarm_id,
    output logic                  snoozing,
    output logic                  ld_err
);

    localparam int unsigned SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} state_e;

    // Time digit registers and their next values
    logic [1:0] h1_q, h1_d;
    logic [3:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;

    // Alarm slots, packed as {h1, h0, m1, m0}
    logic [NUM_ALARMS-1:0][13:0] slot_q;
    logic [NUM_ALARMS-1:0]       valid_q;

    state_e          state_q, state_d;
    logic [7:0]      ring_q, ring_d;
    logic [11:0]     timer_q, timer_d;
    logic [SCW-1:0]  scnt_q, scnt_d;
    logic [AW-1:0]   id_q, id_d;
    logic            err_q;

    logic            time_ok, sel_ok, time_wr, alarm_wr, err_d;
    logic            hit;
    logic [AW-1:0]   hit_id;

    // Load digits form a legal HH:MM (00..23, 00..59)
    assign time_ok = ((H_in1 < 2'd2 && H_in0 <= 4'd9) || (H_in1 == 2'd2 && H_in0 <= 4'd3))
                     && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);

    // Slot index range check is only needed when AW can address past the last slot
    if ((2 ** AW) > NUM_ALARMS) begin : g_sel_chk
        assign sel_ok = (alarm_sel < AW'(NUM_ALARMS));
    end else begin : g_sel_all
        assign sel_ok = 1'b1;
    end

    assign time_wr  = ld_time & time_ok;
    assign alarm_wr = ld_alarm & time_ok & sel_ok;
    assign err_d    = (ld_time & ~time_ok) | (ld_alarm & ~(time_ok & sel_ok));

    // Next time: BCD increment, replaced by a valid ld_time (a rejected load keeps ticking)
    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;
        if (time_wr) begin
            h1_d = H_in1;
            h0_d = H_in0;
            m1_d = M_in1;
            m0_d = M_in0;
            s1_d = 4'd0;
            s0_d = 4'd0;
        end else if (s0_q != 4'd9) begin
            s0_d = s0_q + 4'd1;
        end else begin
            s0_d = 4'd0;
            if (s1_q != 4'd5) begin
                s1_d = s1_q + 4'd1;
            end else begin
                s1_d = 4'd0;
                if (m0_q != 4'd9) begin
                    m0_d = m0_q + 4'd1;
                end else begin
                    m0_d = 4'd0;
                    if (m1_q != 4'd5) begin
                        m1_d = m1_q + 4'd1;
                    end else begin
                        m1_d = 4'd0;
                        if (h1_q == 2'd2 && h0_q == 4'd3) begin
                            h1_d = 2'd0;
                            h0_d = 4'd0;
                        end else if (h0_q == 4'd9) begin
                            h0_d = 4'd0;
                            h1_d = h1_q + 2'd1;
                        end else begin
                            h0_d = h0_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Lowest-index enabled slot equal to the next displayed HH:MM:00
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (valid_q[i] && al_en[i] && s1_d == 4'd0 && s0_d == 4'd0 &&
                slot_q[i] == {h1_d, h0_d, m1_d, m0_d}) begin
                hit    = 1'b1;
                hit_id = AW'(i);
            end
        end
    end

    // Ring / snooze state machine next-state logic
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        timer_d = timer_q;
        scnt_d  = scnt_q;
        id_d    = id_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    state_d = StRinging;
                    id_d    = hit_id;
                    ring_d  = 8'd0;
                    scnt_d  = '0;
                end
            end
            StRinging: begin
                if (stop_al) begin
                    state_d = StIdle;
                end else if (snooze) begin
                    if (scnt_q < SCW'(MAX_SNOOZE)) begin
                        state_d = StSnoozed;
                        timer_d = 12'(SNOOZE_MIN * 60 - 1);
                        scnt_d  = scnt_q + SCW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (ring_q == 8'(RING_TIMEOUT_S - 1)) begin
                    state_d = StIdle;
                end else begin
                    ring_d = ring_q + 8'd1;
                end
            end
            StSnoozed: begin
                if (stop_al) begin
                    state_d = StIdle;
                end else if (timer_q == 12'd0) begin
                    state_d = StRinging;
                    ring_d  = 8'd0;
                end else begin
                    timer_d = timer_q - 12'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Timekeeping, load error pulse and state machine registers
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            h1_q    <= 2'd0;
            h0_q    <= 4'd0;
            m1_q    <= 4'd0;
            m0_q    <= 4'd0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
            err_q   <= 1'b0;
            state_q <= StIdle;
            ring_q  <= 8'd0;
            timer_q <= 12'd0;
            scnt_q  <= '0;
            id_q    <= '0;
        end else begin
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            err_q   <= err_d;
            state_q <= state_d;
            ring_q  <= ring_d;
            timer_q <= timer_d;
            scnt_q  <= scnt_d;
            id_q    <= id_d;
        end
    end

    // Alarm slot storage; matching above uses the pre-write slot contents
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            slot_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_wr && alarm_sel == AW'(i)) begin
                    slot_q[i]  <= {H_in1, H_in0, M_in1, M_in0};
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    assign H_out1   = h1_q;
    assign H_out0   = h0_q;
    assign M_out1   = m1_q;
    assign M_out0   = m0_q;
    assign S_out1   = s1_q;
    assign S_out0   = s0_q;
    assign alarm    = (state_q == StRinging);
    assign snoozing = (state_q == StSnoozed);
    assign alarm_id = id_q;
    assign ld_err   = err_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: the driver queues expected outputs tagged with the
// clock edge they belong to; a monitor pops and compares them on falling edges.
module tb_multi_alarm_clock;

    logic       clk_1s, reset, ld_time, ld_alarm, snooze, stop_al;
    logic [1:0] alarm_sel;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic [3:0] al_en;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
    logic       alarm, snoozing, ld_err;
    logic [1:0] alarm_id;

    multi_alarm_clock dut (
        .clk_1s    (clk_1s),
        .reset     (reset),
        .ld_time   (ld_time),
        .ld_alarm  (ld_alarm),
        .alarm_sel (alarm_sel),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .al_en     (al_en),
        .snooze    (snooze),
        .stop_al   (stop_al),
        .H_out1    (H_out1),
        .H_out0    (H_out0),
        .M_out1    (M_out1),
        .M_out0    (M_out0),
        .S_out1    (S_out1),
        .S_out0    (S_out0),
        .alarm     (alarm),
        .alarm_id  (alarm_id),
        .snoozing  (snoozing),
        .ld_err    (ld_err)
    );

    typedef struct {
        string       name;
        int          at;
        bit          ct;
        logic [23:0] t;
        logic        al;
        logic [1:0]  id;
        logic        snz;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   edges = 0;
    int   total = 0;
    int   bad = 0;
    int   rise_cnt = 0;
    logic prev_alarm = 1'b0;

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    always @(posedge clk_1s) edges <= edges + 1;

    function automatic logic [23:0] cur_time();
        return {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    endfunction

    // Monitor: compare every queued expectation that is due on this edge
    always @(negedge clk_1s) begin
        if (alarm === 1'b1 && prev_alarm !== 1'b1) rise_cnt++;
        prev_alarm = alarm;
        while (sb.size() > 0 && sb[0].at <= edges) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.at < edges) begin
                bad++;
                $display("FAIL %s: checked at edge %0d, required edge %0d", e.name, edges, e.at);
            end else if (alarm !== e.al || alarm_id !== e.id || snoozing !== e.snz ||
                         ld_err !== e.err || (e.ct && cur_time() !== e.t)) begin
                bad++;
                $display("FAIL %s: got t=%06h al=%0b id=%0d snz=%0b err=%0b, want t=%06h%s al=%0b id=%0d snz=%0b err=%0b",
                         e.name, cur_time(), alarm, alarm_id, snoozing, ld_err,
                         e.t, e.ct ? "" : "(ignored)", e.al, e.id, e.snz, e.err);
            end
        end
    end

    // k = 1 means the edge that consumes inputs driven at the current falling edge
    task automatic expect_at(input string name, input int k, input bit ct, input logic [23:0] t,
                             input logic al, input logic [1:0] id, input logic snz,
                             input logic err);
        exp_t e;
        e.name = name;
        e.at   = edges + k;
        e.ct   = ct;
        e.t    = t;
        e.al   = al;
        e.id   = id;
        e.snz  = snz;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic digits(input logic [1:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d);
        H_in1 = a;
        H_in0 = b;
        M_in1 = c;
        M_in0 = d;
    endtask

    task automatic wait_until(input int target);
        while (edges < target) @(negedge clk_1s);
    endtask

    initial begin
        int r0;
        int e1;
        reset = 1'b1;
        ld_time = 0; ld_alarm = 0; snooze = 0; stop_al = 0;
        alarm_sel = 0; al_en = 0;
        digits(0, 0, 0, 0);

        // Reset state
        @(negedge clk_1s);
        expect_at("reset", 1, 1, 24'h000000, 0, 0, 0, 0);
        @(negedge clk_1s);
        reset = 1'b0;

        // Load 23:59 then run through midnight
        ld_time = 1; digits(2, 3, 5, 9);
        expect_at("ld_2359", 1, 1, 24'h235900, 0, 0, 0, 0);
        expect_at("pre_wrap", 60, 1, 24'h235959, 0, 0, 0, 0);
        expect_at("wrap", 61, 1, 24'h000000, 0, 0, 0, 0);
        @(negedge clk_1s);
        ld_time = 0;
        repeat (60) @(negedge clk_1s);

        // Rejected loads: 24:30 and 12:60
        ld_time = 1; digits(2, 4, 3, 0);
        expect_at("bad_hour", 1, 1, 24'h000001, 0, 0, 0, 1);
        @(negedge clk_1s);
        ld_time = 0;
        expect_at("bad_hour_clr", 1, 1, 24'h000002, 0, 0, 0, 0);
        @(negedge clk_1s);
        ld_time = 1; digits(1, 2, 6, 0);
        expect_at("bad_min", 1, 1, 24'h000003, 0, 0, 0, 1);
        @(negedge clk_1s);
        ld_time = 0;
        expect_at("bad_min_clr", 1, 1, 24'h000004, 0, 0, 0, 0);
        @(negedge clk_1s);

        // Slot 2 at 07:00, time 06:59:00, ring on 07:00:00 then stop
        ld_alarm = 1; alarm_sel = 2; digits(0, 7, 0, 0);
        expect_at("ld_alarm", 1, 1, 24'h000005, 0, 0, 0, 0);
        @(negedge clk_1s);
        ld_alarm = 0; ld_time = 1; al_en = 4'b0100; digits(0, 6, 5, 9);
        expect_at("ld_0659", 1, 1, 24'h065900, 0, 0, 0, 0);
        expect_at("t_065958", 59, 1, 24'h065958, 0, 0, 0, 0);
        expect_at("t_065959", 60, 1, 24'h065959, 0, 0, 0, 0);
        expect_at("ring_0700", 61, 1, 24'h070000, 1, 2, 0, 0);
        @(negedge clk_1s);
        ld_time = 0;
        repeat (60) @(negedge clk_1s);
        stop_al = 1;
        expect_at("stop", 1, 1, 24'h070001, 0, 2, 0, 0);
        @(negedge clk_1s);
        stop_al = 0;

        // Slots 0 and 3 at 08:15; load time 08:15 -> slot 0 wins, then timeout
        ld_alarm = 1; alarm_sel = 0; digits(0, 8, 1, 5);
        @(negedge clk_1s);
        alarm_sel = 3;
        @(negedge clk_1s);
        ld_alarm = 0; al_en = 4'b1001; ld_time = 1;
        #1 r0 = rise_cnt;
        expect_at("prio_ring", 1, 1, 24'h081500, 1, 0, 0, 0);
        expect_at("ring_last", 60, 1, 24'h081559, 1, 0, 0, 0);
        expect_at("timeout", 61, 1, 24'h081600, 0, 0, 0, 0);
        @(negedge clk_1s);
        ld_time = 0;
        repeat (5) @(negedge clk_1s);
        al_en = 4'b0000;  // must not cut the ring short
        repeat (57) @(negedge clk_1s);
        #1;
        total++;
        if (rise_cnt - r0 != 1) begin
            bad++;
            $display("FAIL one_ring: got %0d ring events, want 1", rise_cnt - r0);
        end

        // Snooze three times, fourth snooze stops
        @(negedge clk_1s);
        al_en = 4'b0100; ld_time = 1; digits(0, 7, 0, 0);
        expect_at("snz_ring", 1, 1, 24'h070000, 1, 2, 0, 0);
        @(negedge clk_1s);
        ld_time = 0; snooze = 1;
        e1 = edges;
        expect_at("snz1", 1, 0, 24'h0, 0, 2, 1, 0);
        expect_at("snz1_wait", 300, 0, 24'h0, 0, 2, 1, 0);
        expect_at("rering1", 301, 1, 24'h070501, 1, 2, 0, 0);
        @(negedge clk_1s);
        snooze = 0;
        wait_until(e1 + 301);
        snooze = 1;
        expect_at("snz2", 1, 0, 24'h0, 0, 2, 1, 0);
        expect_at("rering2", 301, 1, 24'h071002, 1, 2, 0, 0);
        @(negedge clk_1s);
        snooze = 0;
        wait_until(e1 + 602);
        snooze = 1;
        expect_at("snz3", 1, 0, 24'h0, 0, 2, 1, 0);
        expect_at("rering3", 301, 1, 24'h071503, 1, 2, 0, 0);
        @(negedge clk_1s);
        snooze = 0;
        wait_until(e1 + 903);
        snooze = 1;
        expect_at("snz4_stop", 1, 1, 24'h071504, 0, 2, 0, 0);
        @(negedge clk_1s);
        snooze = 0;
        expect_at("snz4_idle", 5, 0, 24'h0, 0, 2, 0, 0);
        repeat (6) @(negedge clk_1s);

        // Reset asserted mid-snooze clears outputs without waiting for an edge
        ld_time = 1; digits(0, 7, 0, 0);
        expect_at("r_ring", 1, 1, 24'h070000, 1, 2, 0, 0);
        @(negedge clk_1s);
        ld_time = 0; snooze = 1;
        expect_at("r_snz", 1, 0, 24'h0, 0, 2, 1, 0);
        @(negedge clk_1s);
        snooze = 0;
        repeat (3) @(negedge clk_1s);
        @(posedge clk_1s);
        #2 reset = 1'b1;
        expect_at("rst_hold", 0, 1, 24'h000000, 0, 0, 0, 0);
        #1;
        total++;
        if (alarm !== 0 || snoozing !== 0 || alarm_id !== 0 || ld_err !== 0 ||
            cur_time() !== 24'h0) begin
            bad++;
            $display("FAIL rst_now: got t=%06h al=%0b id=%0d snz=%0b err=%0b, want all 0",
                     cur_time(), alarm, alarm_id, snoozing, ld_err);
        end
        repeat (2) @(negedge clk_1s);
        reset = 1'b0;

        repeat (5) begin
            if (sb.size() > 0) @(negedge clk_1s);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
